// File: rtl/inst_fetcher_pkg.sv
// Shared state encoding and defaults for the instruction fetcher.
package inst_fetcher_pkg;

  localparam int IF_STATE_BIT       = 2;
  localparam int ICACHE_IDX_DEFAULT = 4;

  typedef enum logic [IF_STATE_BIT-1:0] {
    IF_FETCH = 2'd0,
    IF_WAIT  = 2'd1,
    IF_READY = 2'd2,
    IF_DRAIN = 2'd3
  } if_state_e;

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetcher_icache_dm.sv
// Direct-mapped one-word-per-line instruction cache: combinational lookup,
// synchronous fill. Used by inst_fetcher only when ICACHE_EN is defined.
module icache_dm #(
  parameter int IDX = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [29:0] lookup_word_i,
  output logic        hit_o,
  output logic [31:0] data_o,
  input  logic        fill_we_i,
  input  logic [29:0] fill_word_i,
  input  logic [31:0] fill_data_i
);

  localparam int LINES = 1 << IDX;
  localparam int TAG_W = 30 - IDX;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [IDX-1:0]   l_idx, f_idx;
  logic [TAG_W-1:0] l_tag, f_tag;

  assign l_idx = lookup_word_i[IDX-1:0];
  assign l_tag = lookup_word_i[29:IDX];
  assign f_idx = fill_word_i[IDX-1:0];
  assign f_tag = fill_word_i[29:IDX];

  assign hit_o  = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign data_o = data_q[l_idx];

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_valid
      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
          valid_q[gi] <= 1'b0;
        else if (fill_we_i && (f_idx == gi[IDX-1:0]))
          valid_q[gi] <= 1'b1;
      end
    end
  endgenerate

  // Tag/data storage needs no reset; the valid bits gate every hit.
  always_ff @(posedge clk_in) begin
    if (fill_we_i) begin
      tag_q[f_idx]  <= f_tag;
      data_q[f_idx] <= fill_data_i;
    end
  end

endmodule

// File: rtl/inst_fetcher.sv
// PC owner and fetch sequencer between memory controller and decoder.
// Optional instruction cache enabled by defining ICACHE_EN.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          ICACHE_IDX = ICACHE_IDX_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  output logic        inst_input,
  output logic [31:0] inst,
  output logic [31:0] inst_addr,
  input  logic        is_stall,
  input  logic [31:0] next_PC,
  input  logic        rob_clear,
  input  logic [31:0] rob_restart_addr
);

  if_state_e   state_q;
  logic [31:0] pc_q;
  logic        mem_req_q;
  logic [31:0] mem_addr_q;
  logic        inst_input_q;
  logic [31:0] inst_q;
  logic [31:0] inst_addr_q;

  logic        cache_hit;
  logic [31:0] cache_data;

  generate
    if (ICACHE_IDX < 1 || ICACHE_IDX > 20) begin : g_idx_check
      $error("inst_fetcher: ICACHE_IDX out of range");
    end
  endgenerate

`ifdef ICACHE_EN
  logic [31:0] lookup_addr;
  logic        fill_we;

  // A redirect takes precedence over the decoder's successor for the lookup.
  assign lookup_addr = rob_clear ? rob_restart_addr : next_PC;
  assign fill_we     = rdy_in && (state_q == IF_WAIT) && mem_done && !rob_clear;

  icache_dm #(.IDX(ICACHE_IDX)) u_icache (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .lookup_word_i (lookup_addr[31:2]),
    .hit_o         (cache_hit),
    .data_o        (cache_data),
    .fill_we_i     (fill_we),
    .fill_word_i   (pc_q[31:2]),
    .fill_data_i   (mem_data)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_data = 32'h0;
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IF_FETCH;
      pc_q         <= RESET_PC;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 32'h0;
      inst_input_q <= 1'b0;
      inst_q       <= 32'h0;
      inst_addr_q  <= 32'h0;
    end else if (rdy_in) begin
      if (rob_clear) begin
        pc_q         <= rob_restart_addr;
        inst_input_q <= 1'b0;
        if (state_q == IF_DRAIN) begin
          if (mem_done) begin
            mem_req_q <= 1'b0;
            state_q   <= IF_FETCH;
          end
        end else if (state_q == IF_WAIT && !mem_done) begin
          // The outstanding request must still complete; swallow it in DRAIN.
          state_q <= IF_DRAIN;
        end else begin
          mem_req_q <= 1'b0;
          if (cache_hit) begin
            inst_q       <= cache_data;
            inst_addr_q  <= rob_restart_addr;
            inst_input_q <= 1'b1;
            state_q      <= IF_READY;
          end else begin
            state_q <= IF_FETCH;
          end
        end
      end else begin
        case (state_q)
          IF_FETCH: begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= word_addr(pc_q);
            state_q    <= IF_WAIT;
          end
          IF_WAIT: begin
            if (mem_done) begin
              inst_q       <= mem_data;
              inst_addr_q  <= pc_q;
              inst_input_q <= 1'b1;
              mem_req_q    <= 1'b0;
              state_q      <= IF_READY;
            end
          end
          IF_READY: begin
            if (!is_stall) begin
              pc_q <= next_PC;
              if (cache_hit) begin
                inst_q       <= cache_data;
                inst_addr_q  <= next_PC;
                inst_input_q <= 1'b1;
              end else begin
                inst_input_q <= 1'b0;
                state_q      <= IF_FETCH;
              end
            end
          end
          IF_DRAIN: begin
            if (mem_done) begin
              mem_req_q <= 1'b0;
              state_q   <= IF_FETCH;
            end
          end
          default: state_q <= IF_FETCH;
        endcase
      end
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign inst_input = inst_input_q;
  assign inst       = inst_q;
  assign inst_addr  = inst_addr_q;

endmodule
